// File: rtl/add8_chk_pkg.sv
// Shared definitions for the add8 result checker: default sizing and FSM encoding.
package add8_chk_pkg;

  localparam int unsigned DEF_WIDTH         = 8;
  localparam int unsigned DEF_CNT_W         = 8;
  localparam int unsigned DEF_SETTLE_CYCLES = 2;
  // Settle counter is sized for the full 0..255 SETTLE_CYCLES range.
  localparam int unsigned SETTLE_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_REPORT = 2'd3
  } chk_state_e;

endpackage

// File: rtl/add8_result_checker_golden.sv
// Combinational reference adder: {cout,sum} = a + b + cin, kept WIDTH+1 wide.
module add8_golden #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   result_c
);

  always_comb begin
    result_c = (WIDTH+1)'(a) + (WIDTH+1)'(b) + (WIDTH+1)'(cin);
  end

endmodule

// File: rtl/add8_result_checker.sv
// Stimulus driver and response checker for an add8 instance: accepts vectors,
// drives the DUT, waits a settle time, compares against a golden adder and keeps stats.
module add8_result_checker
  import add8_chk_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [WIDTH-1:0] vec_a,
  input  logic [WIDTH-1:0] vec_b,
  input  logic             vec_cin,
  output logic [WIDTH-1:0] dut_a,
  output logic [WIDTH-1:0] dut_b,
  output logic             dut_cin,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             res_valid,
  output logic             res_pass,
  output logic [WIDTH:0]   res_exp,
  output logic [CNT_W-1:0] test_nr,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;

  chk_state_e          state;
  chk_state_e          state_next;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                accept_c;
  logic [WIDTH:0]      exp_c;
  logic [WIDTH:0]      obs_c;
  logic                match_c;

  // Golden model works from the registered copy so vec_* may change after accept.
  add8_golden #(
    .WIDTH(WIDTH)
  ) u_golden (
    .a        (dut_a),
    .b        (dut_b),
    .cin      (dut_cin),
    .result_c (exp_c)
  );

  // Next-state, handshake and compare logic.
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    vec_ready  = 1'b0;
    busy       = (state != ST_IDLE);
    obs_c      = {dut_cout, dut_sum};
    match_c    = (obs_c === exp_c);
    case (state)
      ST_IDLE: begin
        vec_ready = !clear;
        if (vec_valid && !clear) begin
          accept_c   = 1'b1;
          state_next = (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt == SETTLE_W'(SETTLE_LAST)) begin
          state_next = ST_CHECK;
        end
      end
      ST_CHECK:  state_next = ST_REPORT;
      ST_REPORT: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      dut_a      <= '0;
      dut_b      <= '0;
      dut_cin    <= 1'b0;
      res_valid  <= 1'b0;
      res_pass   <= 1'b0;
      res_exp    <= '0;
      test_nr    <= '0;
      err_count  <= '0;
    end else begin
      state     <= state_next;
      res_valid <= (state == ST_CHECK);

      if (state == ST_SETTLE) begin
        settle_cnt <= settle_cnt + SETTLE_W'(1);
      end else begin
        settle_cnt <= '0;
      end

      if (accept_c) begin
        dut_a   <= vec_a;
        dut_b   <= vec_b;
        dut_cin <= vec_cin;
      end

      if (state == ST_CHECK) begin
        res_pass <= match_c;
        res_exp  <= exp_c;
      end

      // Clear only acts in IDLE, so it never collides with the REPORT update.
      if (state == ST_IDLE && clear) begin
        test_nr   <= '0;
        err_count <= '0;
      end else if (state == ST_REPORT) begin
        test_nr <= test_nr + CNT_W'(1);
        if (!res_pass && (err_count != {CNT_W{1'b1}})) begin
          err_count <= err_count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_add8_result_checker.sv
// Bench for add8_result_checker: stand-in add8 with injectable faults, table vectors,
// scoreboard on res_valid, and hand sequences for clear, wrap/saturation, reset abort, zero settle.
module tb_add8_result_checker;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       vec_valid;
  logic       vec_ready;
  logic [7:0] vec_a;
  logic [7:0] vec_b;
  logic       vec_cin;
  logic [7:0] dut_a;
  logic [7:0] dut_b;
  logic       dut_cin;
  logic [7:0] dut_sum;
  logic       dut_cout;
  logic       res_valid;
  logic       res_pass;
  logic [8:0] res_exp;
  logic [7:0] test_nr;
  logic [7:0] err_count;
  logic       busy;
  logic [1:0] fault_mode;

  logic       f_vec_valid;
  logic       f_vec_ready;
  logic [7:0] f_vec_a;
  logic [7:0] f_vec_b;
  logic       f_vec_cin;
  logic [7:0] f_dut_a;
  logic [7:0] f_dut_b;
  logic       f_dut_cin;
  logic [7:0] f_dut_sum;
  logic       f_dut_cout;
  logic       f_res_valid;
  logic       f_res_pass;
  logic [8:0] f_res_exp;
  logic [7:0] f_test_nr;
  logic [7:0] f_err_count;
  logic       f_busy;

  typedef struct packed {
    logic [8:0] exp;
    logic       pass;
  } sb_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [1:0] mode;
    logic [8:0] exp;
    logic       pass;
  } vec_t;

  sb_t        sb_q[$];
  vec_t       tbl[8];
  int         checks;
  int         errors;
  logic [7:0] model_tests;
  logic [7:0] model_errs;

  add8_result_checker #(.WIDTH(8), .SETTLE_CYCLES(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .vec_valid(vec_valid), .vec_ready(vec_ready),
    .vec_a(vec_a), .vec_b(vec_b), .vec_cin(vec_cin),
    .dut_a(dut_a), .dut_b(dut_b), .dut_cin(dut_cin),
    .dut_sum(dut_sum), .dut_cout(dut_cout),
    .res_valid(res_valid), .res_pass(res_pass), .res_exp(res_exp),
    .test_nr(test_nr), .err_count(err_count), .busy(busy)
  );

  add8_result_checker #(.WIDTH(8), .SETTLE_CYCLES(0), .CNT_W(8)) u_fast (
    .clk(clk), .rst_n(rst_n), .clear(1'b0),
    .vec_valid(f_vec_valid), .vec_ready(f_vec_ready),
    .vec_a(f_vec_a), .vec_b(f_vec_b), .vec_cin(f_vec_cin),
    .dut_a(f_dut_a), .dut_b(f_dut_b), .dut_cin(f_dut_cin),
    .dut_sum(f_dut_sum), .dut_cout(f_dut_cout),
    .res_valid(f_res_valid), .res_pass(f_res_pass), .res_exp(f_res_exp),
    .test_nr(f_test_nr), .err_count(f_err_count), .busy(f_busy)
  );

  // Stand-in add8 instances; mode 1 forces sum to 0, mode 2 flips the sum LSB.
  always_comb begin
    logic [8:0] full;
    full     = 9'(dut_a) + 9'(dut_b) + 9'(dut_cin);
    dut_cout = full[8];
    dut_sum  = full[7:0];
    if (fault_mode == 2'd1) dut_sum = 8'h00;
    else if (fault_mode == 2'd2) dut_sum = full[7:0] ^ 8'h01;
  end

  always_comb begin
    logic [8:0] ffull;
    ffull      = 9'(f_dut_a) + 9'(f_dut_b) + 9'(f_dut_cin);
    f_dut_cout = ffull[8];
    f_dut_sum  = ffull[7:0];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every res_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_res_valid", 32'(res_valid), 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("res_exp", 32'(res_exp), 32'(e.exp));
        check("res_pass", 32'(res_pass), 32'(e.pass));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_vec(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [1:0] mode, input logic [8:0] exp, input logic pass);
    int n;
    sb_t e;
    n = 0;
    @(negedge clk);
    while (!vec_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!vec_ready) check("ready_timeout", 32'(vec_ready), 32'd1);
    fault_mode = mode;
    vec_a      = a;
    vec_b      = b;
    vec_cin    = cin;
    vec_valid  = 1'b1;
    @(posedge clk);
    e.exp  = exp;
    e.pass = pass;
    sb_q.push_back(e);
    model_tests = model_tests + 8'd1;
    if (!pass && model_errs != 8'hFF) model_errs = model_errs + 8'd1;
    #1;
    vec_valid = 1'b0;
    vec_a     = ~a;
    vec_b     = ~b;
    vec_cin   = ~cin;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || sb_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 32'(busy || sb_q.size() != 0), 32'd0);
  endtask

  initial begin
    int k;
    checks = 0; errors = 0;
    model_tests = 8'd0; model_errs = 8'd0;
    rst_n = 1'b0; clear = 1'b0; vec_valid = 1'b0;
    vec_a = 8'h00; vec_b = 8'h00; vec_cin = 1'b0; fault_mode = 2'd0;
    f_vec_valid = 1'b0; f_vec_a = 8'h00; f_vec_b = 8'h00; f_vec_cin = 1'b0;

    tbl[0] = '{8'hFF, 8'h00, 1'b0, 2'd0, 9'h0FF, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b1, 2'd1, 9'h101, 1'b0};
    tbl[2] = '{8'h80, 8'h80, 1'b0, 2'd0, 9'h100, 1'b1};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 2'd0, 9'h1FF, 1'b1};
    tbl[4] = '{8'h00, 8'h00, 1'b0, 2'd1, 9'h000, 1'b1};
    tbl[5] = '{8'h55, 8'hAA, 1'b1, 2'd0, 9'h100, 1'b1};
    tbl[6] = '{8'h12, 8'h34, 1'b0, 2'd2, 9'h046, 1'b0};
    tbl[7] = '{8'h7F, 8'h00, 1'b1, 2'd0, 9'h080, 1'b1};

    // Reset held three cycles.
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_vec_ready", 32'(vec_ready), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_pass", 32'(res_pass), 32'd0);
    check("rst_res_exp", 32'(res_exp), 32'd0);
    check("rst_test_nr", 32'(test_nr), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_dut_a", 32'({dut_a, dut_b, dut_cin}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Zero settle: result two cycles after accept, ready again on the third.
    f_vec_a = 8'h3C; f_vec_b = 8'hC4; f_vec_cin = 1'b1; f_vec_valid = 1'b1;
    check("fast_ready", 32'(f_vec_ready), 32'd1);
    @(posedge clk); #1;
    f_vec_valid = 1'b0; f_vec_a = 8'h00;
    @(negedge clk);
    check("fast_c1_res_valid", 32'(f_res_valid), 32'd0);
    check("fast_c1_busy", 32'(f_busy), 32'd1);
    @(negedge clk);
    check("fast_c2_res_valid", 32'(f_res_valid), 32'd1);
    check("fast_c2_res_exp", 32'(f_res_exp), 32'h101);
    check("fast_c2_res_pass", 32'(f_res_pass), 32'd1);
    check("fast_c2_ready", 32'(f_vec_ready), 32'd0);
    @(negedge clk);
    check("fast_c3_ready", 32'(f_vec_ready), 32'd1);
    check("fast_test_nr", 32'(f_test_nr), 32'd1);
    check("fast_err_count", 32'(f_err_count), 32'd0);

    // Latency with SETTLE_CYCLES=2: res_valid in cycle 4, ready in cycle 5.
    send_vec(8'hFF, 8'h00, 1'b0, 2'd0, 9'h0FF, 1'b1);
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (res_valid) begin
        k = i;
        break;
      end
    end
    check("latency_res_valid_cycle", 32'(k), 32'd4);
    @(negedge clk);
    check("latency_ready_cycle", 32'(vec_ready), 32'd1);
    check("latency_err_count", 32'(err_count), 32'd0);
    check("latency_test_nr", 32'(test_nr), 32'd1);

    // Table vectors, back to back.
    for (int i = 0; i < 8; i++) begin
      send_vec(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].mode, tbl[i].exp, tbl[i].pass);
    end
    drain();
    check("table_test_nr", 32'(test_nr), 32'(model_tests));
    check("table_err_count", 32'(err_count), 32'(model_errs));
    check("table_err_count_abs", 32'(err_count), 32'd2);

    // Clear wins over vec_valid in IDLE.
    @(negedge clk);
    fault_mode = 2'd0;
    vec_a = 8'h01; vec_b = 8'h02; vec_cin = 1'b0;
    clear = 1'b1; vec_valid = 1'b1;
    #1;
    check("clear_vec_ready", 32'(vec_ready), 32'd0);
    @(negedge clk);
    check("clear_no_accept", 32'(busy), 32'd0);
    check("clear_test_nr", 32'(test_nr), 32'd0);
    check("clear_err_count", 32'(err_count), 32'd0);
    model_tests = 8'd0; model_errs = 8'd0;
    clear = 1'b0;
    #1;
    check("after_clear_ready", 32'(vec_ready), 32'd1);
    @(posedge clk);
    sb_q.push_back('{9'h003, 1'b1});
    model_tests = model_tests + 8'd1;
    #1;
    vec_valid = 1'b0;
    @(negedge clk);
    check("after_clear_accepted", 32'(busy), 32'd1);
    drain();
    check("after_clear_test_nr", 32'(test_nr), 32'd1);

    // 300 failing vectors: test_nr wraps, err_count saturates.
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_tests = 8'd0; model_errs = 8'd0;
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      send_vec(ra, rb, rc, 2'd2, 9'(ra) + 9'(rb) + 9'(rc), 1'b0);
    end
    drain();
    check("wrap_test_nr", 32'(test_nr), 32'd44);
    check("sat_err_count", 32'(err_count), 32'hFF);

    // Reset during SETTLE aborts the test silently.
    send_vec(8'hAB, 8'h11, 1'b0, 2'd0, 9'h0BC, 1'b1);
    @(negedge clk);
    check("abort_in_settle", 32'(busy), 32'd1);
    sb_q.delete();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_tests = 8'd0; model_errs = 8'd0;
    check("abort_dut_a", 32'(dut_a), 32'd0);
    check("abort_test_nr", 32'(test_nr), 32'd0);
    check("abort_err_count", 32'(err_count), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_res_valid", 32'(res_valid), 32'd0);
    end
    check("abort_test_nr_after", 32'(test_nr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
